// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// The transmit stage imports the same package so both ends agree on bit timing.
package uart_pkg;

  localparam int FREQ  = 12000000;
  localparam int BAUD  = 9600;
  localparam int LIM   = FREQ / BAUD;
  localparam int HALF  = LIM / 2;
  localparam int CNT_W = $clog2(LIM);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both stages reset to 1 so a reset never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// Frame-aligned 8N1 byte receiver with a valid/ack holding register,
// framing-error pulse and sticky overrun flag.
module uart_rx_byte
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic             rx_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             half_end;
  logic             bit_end;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rx_s)
  );

  assign half_end = (cnt == CNT_W'(HALF - 1));
  assign bit_end  = (cnt == CNT_W'(LIM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // The ack clears the holding register; a load later in this block overrides it.
      if (data_valid && data_ack) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (half_end) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (idx == 3'd7) begin
              state <= STOP;
              idx   <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              if (data_valid && !data_ack) overrun <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= RECOVER;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // A held-low line (break) must return high before a new start bit counts.
        RECOVER: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scenario bench for uart_rx_byte: bytes are queued when a good frame is driven
// and popped when the load cycle (start fall + 11878 clocks) is reached.
module tb_uart_rx_byte;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fe_count = 0;
  logic [7:0] exp_q[$];

  uart_rx_byte dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_err === 1'b1) fe_count <= fe_count + 1;

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Drives the first nbits line bits (start, data LSB first, stop), each LIM clocks.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    if (stop_bit && nbits == 10) exp_q.push_back(b);
    for (int j = 0; j < nbits; j++) begin
      rxd = bits[j];
      repeat (LIM) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rxd = 1'b1; data_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, data_valid, frame_err, overrun, busy} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_state got=%h exp=000", {data_out, data_valid, frame_err, overrun, busy});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_frame;
    int p0, fe0;
    logic [7:0] exp;
    p0 = cyc; fe0 = fe_count;
    fork
      drive_frame(8'h53, 1'b1, 10);
      begin
        wait_until(p0 + 11877);
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL single_pre_load valid=%b busy=%b exp valid=0 busy=1", data_valid, busy);
        end
        wait_until(p0 + 11878);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (data_valid !== 1'b1 || data_out !== exp) begin
          failures++;
          $display("[TB] FAIL single_load valid=%b data=%h exp valid=1 data=%h", data_valid, data_out, exp);
        end
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL single_busy got=%b exp=0", busy);
        end
      end
    join
    checks++;
    if (fe_count != fe0) begin
      failures++;
      $display("[TB] FAIL single_frame_err pulses=%0d exp=0", fe_count - fe0);
    end
  endtask

  task automatic test_ack_at_load;
    int p0;
    logic [7:0] exp;
    p0 = cyc;
    fork
      drive_frame(8'h41, 1'b1, 10);
      begin
        wait_until(p0 + 11877);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h53) begin
          failures++;
          $display("[TB] FAIL ackload_pre valid=%b data=%h exp valid=1 data=53", data_valid, data_out);
        end
        data_ack = 1'b1;
        wait_until(p0 + 11878);
        data_ack = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (data_valid !== 1'b1 || data_out !== exp || overrun !== 1'b0) begin
          failures++;
          $display("[TB] FAIL ackload_load valid=%b data=%h ovr=%b exp valid=1 data=%h ovr=0",
                   data_valid, data_out, overrun, exp);
        end
      end
    join
  endtask

  task automatic test_back_to_back;
    int p0;
    logic [7:0] exp;
    p0 = cyc;
    fork
      drive_frame(8'h70, 1'b1, 10);
      begin
        wait_until(p0 + 11877);
        checks++;
        if (overrun !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_pre_overrun got=%b exp=0", overrun);
        end
        wait_until(p0 + 11878);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (data_valid !== 1'b1 || data_out !== exp || overrun !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b_overrun valid=%b data=%h ovr=%b exp valid=1 data=%h ovr=1",
                   data_valid, data_out, overrun, exp);
        end
      end
    join
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_ack_clear valid=%b ovr=%b exp valid=0 ovr=0", data_valid, overrun);
    end
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'h70) begin
      failures++;
      $display("[TB] FAIL idle_ack_ignored valid=%b data=%h exp valid=0 data=70", data_valid, data_out);
    end
  endtask

  task automatic test_glitch;
    int p0, fe0;
    p0 = cyc; fe0 = fe_count;
    rxd = 1'b0;
    wait_until(p0 + 300);
    rxd = 1'b1;
    wait_until(p0 + 627);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL glitch_busy_hold got=%b exp=1", busy);
    end
    wait_until(p0 + 628);
    checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || fe_count != fe0) begin
      failures++;
      $display("[TB] FAIL glitch_drop busy=%b valid=%b fe=%0d exp busy=0 valid=0 fe=0",
               busy, data_valid, fe_count - fe0);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_frame_error;
    int p0, fe0;
    logic [7:0] exp;
    p0 = cyc; fe0 = fe_count;
    fork
      drive_frame(8'h6E, 1'b0, 10);
      begin
        wait_until(p0 + 11877);
        checks++;
        if (frame_err !== 1'b0) begin
          failures++;
          $display("[TB] FAIL ferr_early got=%b exp=0", frame_err);
        end
        wait_until(p0 + 11878);
        checks++;
        if (frame_err !== 1'b1 || data_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL ferr_pulse ferr=%b valid=%b exp ferr=1 valid=0", frame_err, data_valid);
        end
        wait_until(p0 + 11879);
        checks++;
        if (frame_err !== 1'b0) begin
          failures++;
          $display("[TB] FAIL ferr_width got=%b exp=0", frame_err);
        end
      end
    join
    repeat (2000) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || data_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ferr_break busy=%b valid=%b exp busy=1 valid=0", busy, data_valid);
    end
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ferr_recover busy=%b exp=0", busy);
    end
    p0 = cyc;
    fork
      drive_frame(8'h70, 1'b1, 10);
      begin
        wait_until(p0 + 11877);
        checks++;
        if (data_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL ferr_spurious valid=%b exp=0", data_valid);
        end
        wait_until(p0 + 11878);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (data_valid !== 1'b1 || data_out !== exp) begin
          failures++;
          $display("[TB] FAIL ferr_next_byte valid=%b data=%h exp valid=1 data=%h", data_valid, data_out, exp);
        end
      end
    join
    checks++;
    if (fe_count - fe0 != 1) begin
      failures++;
      $display("[TB] FAIL ferr_count got=%0d exp=1", fe_count - fe0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int p0, fe0;
    logic [7:0] exp;
    p0 = cyc;
    drive_frame(8'h53, 1'b1, 5);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({data_out, data_valid, frame_err, overrun, busy} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL midframe_reset got=%h exp=000", {data_out, data_valid, frame_err, overrun, busy});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    p0 = cyc; fe0 = fe_count;
    fork
      drive_frame(8'h41, 1'b1, 10);
      begin
        wait_until(p0 + 11878);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (data_valid !== 1'b1 || data_out !== exp) begin
          failures++;
          $display("[TB] FAIL midframe_next valid=%b data=%h exp valid=1 data=%h", data_valid, data_out, exp);
        end
      end
    join
    checks++;
    if (fe_count != fe0 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL midframe_clean fe=%0d queued=%0d exp fe=0 queued=0", fe_count - fe0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ack_at_load();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Byte-level UART receiver that consumes the serial line driven by the transmit stage: 8N1, LSB first, idle high.
- Detects the start bit, samples each bit at its centre, checks the stop bit, and presents a byte through a valid/ack holding register.
- Reports framing errors and overruns.
- Replaces free-running 10-bit shift capture on the receive side with frame-aligned reception.

Parameters:
- FREQ, 12000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- LIM, FREQ/BAUD (1250), clocks per bit; derived, not overridden.
- HALF, LIM/2 (625), clocks to start-bit centre; derived.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rxd  in  1  serial line; asynchronous to clk; idle high.
- data_out  out  8  received byte; stable while data_valid=1.
- data_valid  out  1  byte available; held until acknowledged.
- data_ack  in  1  consumer accepts byte; honoured only when data_valid=1.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a byte was overwritten while unacknowledged.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, counters=0, synchroniser FFs=1, data_out=0x00, data_valid=0, frame_err=0, overrun=0, busy=0.
- rxd passes through a 2-FF synchroniser; rx_s denotes its output. All decisions use rx_s only.
- Single bit-timer counter cnt, 0..LIM-1 (11 bits), plus bit index 0..7.
- States: IDLE, START, DATA, STOP, RECOVER.
- IDLE: rx_s=0 at cycle t0 -> START at t0+1 with cnt=0.
- START: at cnt=HALF-1 (cycle t0+625), sample rx_s.
  - 0 -> DATA, cnt=0, idx=0.
  - 1 -> glitch; return to IDLE with no flags.
- DATA: at cnt=LIM-1, shift rx_s into the MSB of the shift register (shift right) and increment idx.
  - Bit k is sampled at t0+625+1250*(k+1).
  - After idx=7 -> STOP, cnt=0.
- STOP: sample at cnt=LIM-1 (t0+11875).
  - rx_s=1: load data_out, set data_valid; both visible at t0+11876; -> IDLE.
  - rx_s=0: frame_err=1 for exactly cycle t0+11876; byte discarded; data_out/data_valid unchanged; -> RECOVER.
- RECOVER: wait until rx_s=1, then -> IDLE. This prevents a break condition from being read as a start bit.
- Handshake:
  - data_valid && data_ack -> data_valid=0 and overrun=0 next cycle.
  - data_ack while data_valid=0 is ignored.
- Load while data_valid=1 and no ack in the same cycle: data_out is overwritten, data_valid stays 1, overrun set.
- Load and ack in the same cycle: the load wins; data_valid stays 1; overrun not set.
- rst mid-frame: frame is abandoned. After release, reception restarts from IDLE; the first falling edge of rx_s begins a new frame.
- No arithmetic wrap: cnt is always cleared at its terminal value. idx never exceeds 7.

Decomposition:
- Package uart_pkg holds:
  - FREQ, BAUD, LIM, HALF constants.
  - State enum {IDLE, START, DATA, STOP, RECOVER}, 3 bits.
  - Shared by the transmit stage.
- One sub-module: uart_sync2, a 2-FF synchroniser with async active-high reset to 1. Everything else is in one module.

Test Plan:
- Frame 0x53 (line bits 0,1,1,0,0,1,0,1,0,1) -> data_out=0x53; data_valid rises exactly 11876 cycles after rx_s first low; frame_err stays 0; busy low after load.
- rxd low for 300 cycles then high -> no data_valid, no frame_err; busy drops at t0+626; a following frame 0x70 is received correctly.
- Frame 0x6E with stop bit 0, line held low 2000 more cycles, then frame 0x70 -> one frame_err pulse; data_valid=0 until 0x70 arrives; data_out=0x70 with no spurious byte.
- Back-to-back frames 0x6E, 0x70 without ack -> data_out=0x70, data_valid=1, overrun=1. data_ack for one cycle -> data_valid=0 and overrun=0 the next cycle.
- data_ack asserted in the exact load cycle of a second byte 0x41 -> data_valid stays 1, data_out=0x41, overrun=0.
- rst pulse during DATA bit 4 of 0x53 -> all outputs at reset values immediately (async). After release, frame 0x41 -> data_out=0x41, no frame_err.
